sobel_deadlock_detector: RTL and testbench

//  - Detects AXIS deadlock in the sobel_hls co-simulation.
//  - Consumes per-channel AXIS blocked flags, per-process idle flags and
//    top-level block flags; raises a sticky `block` output once the kernel
//    has been stalled for THRESHOLD consecutive cycles.
//  - Sits between the kernel-monitor top wiring and the bench deadlock trigger.
//  - Captures which channels were blocked at the moment of detection.

---
 rtl/sobel_deadlock_detector.sv | 172 +++++++++++++++++
 tb/tb_sobel_deadlock_detector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_deadlock_detector.sv
// ---------------------------------------------------------------------------
// sobel_deadlock_detector
//
// Purpose:
//   Watches the AXIS blocked flags, per-process idle flags and top-level
//   block flags of the sobel_hls kernel. It raises a sticky `block` flag once
//   the kernel has been stalled for THRESHOLD consecutive cycles. At that
//   moment it also snapshots which AXIS channels were blocked.
//
// Ports:
//   clock            in   kernel monitor clock
//   reset            in   asynchronous, active-high reset
//   axis_block_sigs  in   [N_AXIS]  1 = AXIS channel k blocked (owned by process k+1)
//   inst_idle_sigs   in   [N_INST]  1 = process idle (process 0 = top)
//   inst_block_sigs  in   [N_BLK]   1 = top-level process blocked
//   clear            in   synchronous clear of detection state (1-cycle pulse)
//   block            out  sticky deadlock flag (state == DETECTED)
//   blocked_chan     out  [N_AXIS]  axis_block_sigs captured on detection
//   stall_cnt        out  [CNT_W]   consecutive stalled cycles, saturating
//   fsm_state        out  [2]       FSM state: 0 = RUN, 1 = ARMED, 2 = DETECTED
//
// Optional feature, enabled by defining the macro DEADLOCK_DET_TIMESTAMP_EN:
//   cycle_cnt        out  [32]  free-running cycle counter (wraps)
//   detect_time      out  [32]  cycle_cnt value latched on entry to DETECTED
//
// Valid/ready: this block has no handshakes. Every input is sampled on every
// rising clock edge, and every output is a registered level.
// ---------------------------------------------------------------------------
module sobel_deadlock_detector #(
    parameter int N_AXIS    = 2,
    parameter int N_INST    = 3,
    parameter int N_BLK     = 1,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_BLK-1:0]  inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic [N_AXIS-1:0] blocked_chan,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        fsm_state
`ifdef DEADLOCK_DET_TIMESTAMP_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       detect_time
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ARMED    = 2'd1,
        DETECTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              capture;

    logic [N_AXIS-1:0] child_stuck;
    logic              top_stuck;
    logic              stalled_raw;
    logic              stalled;

    // Channel k belongs to process k+1. That child counts as stuck when it is
    // idle or when its channel is blocked. If every process is idle and no
    // channel is blocked, the kernel has completed. That case is not a
    // deadlock, so at least one blocked channel is required.
    always_comb begin
        child_stuck = inst_idle_sigs[N_INST-1:1] | axis_block_sigs;
        top_stuck   = inst_idle_sigs[0] | (|inst_block_sigs) | (&child_stuck);
        stalled_raw = top_stuck & (&child_stuck) & (|axis_block_sigs);
        // An unknown input on the monitor must never count as a stall.
        stalled     = (stalled_raw === 1'b1);
    end

    assign cnt_inc = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_W'(1);

    // Next state and counter. clear takes priority over every stall update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = stall_cnt;
        capture   = 1'b0;
        if (clear) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (stalled) begin
                        cnt_nxt = CNT_W'(1);
                        if (THRESH == CNT_W'(1)) begin
                            state_nxt = DETECTED;
                            capture   = 1'b1;
                        end else begin
                            state_nxt = ARMED;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                ARMED: begin
                    if (stalled) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == THRESH) begin
                            state_nxt = DETECTED;
                            capture   = 1'b1;
                        end
                    end else begin
                        // Any break in the stall restarts the count.
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                DETECTED: begin
                    // The state is sticky. The counter keeps tracking the
                    // current consecutive stall run, and saturates.
                    cnt_nxt = stalled ? cnt_inc : '0;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            stall_cnt    <= '0;
            blocked_chan <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= cnt_nxt;
            if (clear) begin
                blocked_chan <= '0;
            end else if (capture) begin
                blocked_chan <= axis_block_sigs;
            end
        end
    end

    assign block     = (state == DETECTED);
    assign fsm_state = state;

`ifdef DEADLOCK_DET_TIMESTAMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            detect_time <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (clear) begin
                detect_time <= '0;
            end else if (capture) begin
                // Latch the count of the cycle on which the final stall was sampled.
                detect_time <= cycle_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sobel_deadlock_detector.sv
// ---------------------------------------------------------------------------
// tb_sobel_deadlock_detector
//
// Purpose:
//   Self-checking bench for sobel_deadlock_detector with default parameters.
//
// Structure:
//   - A clock/reset block.
//   - Driver tasks that change inputs on the falling edge.
//   - A reference model that describes detection as "a stall run reached
//     THRESHOLD since the last clear/reset". It is updated on each rising
//     edge and compared just after that edge.
//   - Directed scenarios with literal expectations.
//   - Randomised segments.
//   - A final report.
//
// Define DEADLOCK_DET_TIMESTAMP_EN to also check cycle_cnt and detect_time.
// ---------------------------------------------------------------------------
module tb_sobel_deadlock_detector;

    localparam int N_AXIS    = 2;
    localparam int N_INST    = 3;
    localparam int N_BLK     = 1;
    localparam int THRESHOLD = 16;
    localparam int CNT_W     = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N_AXIS-1:0] axis_block_sigs = '0;
    logic [N_INST-1:0] inst_idle_sigs  = '0;
    logic [N_BLK-1:0]  inst_block_sigs = '0;
    logic              clear = 1'b0;
    logic              block;
    logic [N_AXIS-1:0] blocked_chan;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        fsm_state;
`ifdef DEADLOCK_DET_TIMESTAMP_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       detect_time;
`endif

    int checks = 0;
    int errors = 0;

    sobel_deadlock_detector #(
        .N_AXIS(N_AXIS), .N_INST(N_INST), .N_BLK(N_BLK),
        .THRESHOLD(THRESHOLD), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .clear(clear),
        .block(block),
        .blocked_chan(blocked_chan),
        .stall_cnt(stall_cnt),
        .fsm_state(fsm_state)
`ifdef DEADLOCK_DET_TIMESTAMP_EN
        ,
        .cycle_cnt(cycle_cnt),
        .detect_time(detect_time)
`endif
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_run : length of the current consecutive stall run (saturating)
    // m_det : a run reached THRESHOLD since the last clear/reset
    logic [CNT_W-1:0]  m_run  = '0;
    logic              m_det  = 1'b0;
    logic [N_AXIS-1:0] m_chan = '0;
    logic [31:0]       m_cyc  = '0;
    logic [31:0]       m_dt   = '0;
    logic              prev_block = 1'b0;

    function automatic logic model_stalled(input logic [1:0] a, input logic [2:0] i, input logic b);
        logic c0, c1, all_child, top;
        c0        = i[1] | a[0];
        c1        = i[2] | a[1];
        all_child = c0 & c1;
        top       = i[0] | b | all_child;
        return ((top & all_child & (a[0] | a[1])) === 1'b1);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_run = '0; m_det = 1'b0; m_chan = '0; m_cyc = '0; m_dt = '0;
        end else begin
            if (clear) begin
                m_run = '0; m_det = 1'b0; m_chan = '0; m_dt = '0;
            end else begin
                if (model_stalled(axis_block_sigs, inst_idle_sigs, inst_block_sigs[0]))
                    m_run = (m_run == {CNT_W{1'b1}}) ? m_run : m_run + 1'b1;
                else
                    m_run = '0;
                if (!m_det && m_run == CNT_W'(THRESHOLD)) begin
                    m_det  = 1'b1;
                    m_chan = axis_block_sigs;
                    m_dt   = m_cyc;
                end
            end
            m_cyc = m_cyc + 32'd1;
        end
        #2;
        chk("block", {31'd0, block}, {31'd0, m_det});
        chk("blocked_chan", {30'd0, blocked_chan}, {30'd0, m_chan});
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_run});
        chk("fsm_state", {30'd0, fsm_state},
            m_det ? 32'd2 : (m_run != '0 ? 32'd1 : 32'd0));
`ifdef DEADLOCK_DET_TIMESTAMP_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("detect_time", detect_time, m_dt);
        if (block && !prev_block) $display("block rose, detect_time=%0d", detect_time);
`endif
        prev_block = block;
    end

    // ---------------- driver ----------------
    task automatic apply(input logic [1:0] a, input logic [2:0] i, input logic b,
                         input logic c, input int n);
        for (int k = 0; k < n; k++) begin
            axis_block_sigs    = a;
            inst_idle_sigs     = i;
            inst_block_sigs[0] = b;
            clear              = c;
            @(negedge clock);
        end
    endtask

    // Patterns that satisfy the stall rule.
    logic [1:0] st_a [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [2:0] st_i [4] = '{3'b100, 3'b010, 3'b000, 3'b101};
    logic       st_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] xa;
        int len, kind, idx;

        // 1. Reset held 3 cycles with the inputs toggling.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            axis_block_sigs = 2'($urandom_range(0, 3));
            inst_idle_sigs  = 3'($urandom_range(0, 7));
            inst_block_sigs = 1'($urandom_range(0, 1));
            chk("rst_block", {31'd0, block}, 32'd0);
            chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
            chk("rst_chan", {30'd0, blocked_chan}, 32'd0);
        end
        apply(2'b00, 3'b000, 1'b0, 1'b0, 1);
        reset = 1'b0;
        apply(2'b00, 3'b000, 1'b0, 1'b0, 2);

        // 2. Steady stall: block rises on the 16th edge.
        apply(2'b01, 3'b100, 1'b0, 1'b0, 15);
        chk("t2_cnt15", {16'd0, stall_cnt}, 32'd15);
        chk("t2_block_lo", {31'd0, block}, 32'd0);
        apply(2'b01, 3'b100, 1'b0, 1'b0, 1);
        chk("t2_block_hi", {31'd0, block}, 32'd1);
        chk("t2_chan", {30'd0, blocked_chan}, 32'd1);

        // 5. Clear during a continued stall, then detect again.
        apply(2'b01, 3'b100, 1'b0, 1'b1, 1);
        chk("t5_block_clr", {31'd0, block}, 32'd0);
        chk("t5_cnt_clr", {16'd0, stall_cnt}, 32'd0);
        chk("t5_chan_clr", {30'd0, blocked_chan}, 32'd0);
        apply(2'b01, 3'b100, 1'b0, 1'b0, 15);
        chk("t5_block_lo", {31'd0, block}, 32'd0);
        apply(2'b01, 3'b100, 1'b0, 1'b0, 1);
        chk("t5_block_hi", {31'd0, block}, 32'd1);

        // 3. A single break restarts the count.
        apply(2'b00, 3'b000, 1'b0, 1'b1, 1);
        apply(2'b10, 3'b010, 1'b1, 1'b0, 15);
        chk("t3_cnt15", {16'd0, stall_cnt}, 32'd15);
        apply(2'b01, 3'b000, 1'b0, 1'b0, 1);
        chk("t3_cnt_break", {16'd0, stall_cnt}, 32'd0);
        apply(2'b10, 3'b010, 1'b1, 1'b0, 15);
        chk("t3_block_lo", {31'd0, block}, 32'd0);
        apply(2'b00, 3'b000, 1'b0, 1'b0, 1);

        // 4. Completion (all idle, nothing blocked) is not a deadlock.
        apply(2'b00, 3'b111, 1'b0, 1'b0, 100);
        chk("t4_block", {31'd0, block}, 32'd0);
        chk("t4_cnt", {16'd0, stall_cnt}, 32'd0);

        // Randomised segments: stall runs, random noise, completion, X inputs.
        for (int s = 0; s < 150; s++) begin
            len  = $urandom_range(1, 40);
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 3);
            for (int c = 0; c < len; c++) begin
                if (kind < 6)
                    apply(st_a[idx], st_i[idx], st_b[idx], ($urandom_range(0, 99) < 2), 1);
                else if (kind < 8)
                    apply(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2), 1);
                else if (kind == 8)
                    apply(2'b00, 3'b111, 1'b0, 1'b0, 1);
                else begin
                    xa = ($urandom_range(0, 1) != 0) ? 2'b1x : 2'bx0;
                    apply(xa, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1);
                end
            end
        end

        // 6b. Asynchronous reset in the middle of ARMED.
        apply(2'b00, 3'b000, 1'b0, 1'b1, 1);
        apply(2'b01, 3'b100, 1'b0, 1'b0, 7);
        chk("t6_cnt7", {16'd0, stall_cnt}, 32'd7);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("t6_rst_block", {31'd0, block}, 32'd0);
        chk("t6_rst_chan", {30'd0, blocked_chan}, 32'd0);
        chk("t6_rst_state", {30'd0, fsm_state}, 32'd0);
`ifdef DEADLOCK_DET_TIMESTAMP_EN
        chk("t6_rst_cyc", cycle_cnt, 32'd0);
        chk("t6_rst_dt", detect_time, 32'd0);
`endif
        apply(2'b00, 3'b000, 1'b0, 1'b0, 1);
        reset = 1'b0;

`ifdef DEADLOCK_DET_TIMESTAMP_EN
        // 6a. Stall starts at cycle_cnt=40, so detection latches 55.
        for (int g = 0; g < 200 && cycle_cnt != 32'd40; g++)
            apply(2'b00, 3'b000, 1'b0, 1'b0, 1);
        chk("t6_cyc40", cycle_cnt, 32'd40);
        apply(2'b01, 3'b100, 1'b0, 1'b0, 16);
        chk("t6_block", {31'd0, block}, 32'd1);
        chk("t6_detect_time", detect_time, 32'd55);
`endif
        apply(2'b00, 3'b000, 1'b0, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
